// File: rtl/sum_fxp_pipe.sv
// sum_fxp_pipe -- pipelined signed fixed-point adder tree.
//
// Sums `size` two's-complement operands of N = n_int+n_mant+1 bits. Operands
// are sign-extended by L = clog2(size) guard bits, so the tree itself cannot
// overflow. The final sum is narrowed back to N bits and registered. A valid
// shift register runs alongside the data. Latency is
// LAT = floor(L/adders_comb) + 1 en-high cycles.
//
// Optional build macro SUM_FXP_SAT_EN: when defined, an overflowing sum
// clamps to the N-bit limits. Otherwise it wraps. ovf is identical in both
// builds.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   en          pipeline advance; low freezes data, valid and ovf registers
//   clr         synchronous clear of ovf_sticky (loses to a same-cycle set)
//   in_valid    operands valid this cycle
//   in          size x N signed operands
//   out_valid   out holds a new sum
//   out         N-bit signed sum
//   ovf         out was clamped/wrapped for this sample
//   ovf_sticky  latched OR of qualified ovf since reset or clr
module sum_fxp_pipe #(
  parameter int size        = 2,
  parameter int n_int       = 8,
  parameter int n_mant      = 23,
  parameter int adders_comb = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic                              clr,
  input  logic                              in_valid,
  input  logic [size-1:0][n_int+n_mant:0]   in,
  output logic                              out_valid,
  output logic [n_int+n_mant:0]             out,
  output logic                              ovf,
  output logic                              ovf_sticky
);
  localparam int N   = n_int + n_mant + 1;
  localparam int L   = (size > 1) ? $clog2(size) : 0;
  localparam int W   = N + L;
  localparam int LAT = L / adders_comb + 1;

  // Entry count feeding layer `lay`; an odd leftover is carried unsummed.
  function automatic int cnt_at(int lay);
    int c = size;
    for (int k = 0; k < lay; k++) c = (c + 1) / 2;
    return c;
  endfunction

  // lvl[i] is the input to layer i; lvl[L][0] is the full-precision sum.
  logic signed [W-1:0] lvl [0:L][size];

  for (genvar j = 0; j < size; j++) begin : g_ext
    assign lvl[0][j] = W'($signed(in[j]));
  end

  for (genvar i = 0; i < L; i++) begin : g_lay
    localparam int CI  = cnt_at(i);
    localparam int CO  = cnt_at(i + 1);
    localparam bit REG = ((i + 1) % adders_comb) == 0;
    for (genvar j = 0; j < size; j++) begin : g_node
      if (j < CO) begin : g_act
        logic signed [W-1:0] s;
        if (2 * j + 1 < CI) begin : g_pair
          assign s = lvl[i][2*j] + lvl[i][2*j+1];
        end else begin : g_pass
          assign s = lvl[i][2*j];
        end
        if (REG) begin : g_reg
          logic signed [W-1:0] q;
          always_ff @(posedge clk or negedge rst)
            if (!rst)    q <= '0;
            else if (en) q <= s;
          assign lvl[i+1][j] = q;
        end else begin : g_cmb
          assign lvl[i+1][j] = s;
        end
      end else begin : g_idle
        assign lvl[i+1][j] = '0;
      end
    end
  end

  // Narrowing: the sum fits in N bits iff the top L+1 bits are all equal.
  logic signed [W-1:0] s_fin;
  logic [L:0]          s_hi;
  logic                ovf_c;
  logic [N-1:0]        out_c;

  assign s_fin = lvl[L][0];
  assign s_hi  = s_fin[W-1:N-1];
  assign ovf_c = !((&s_hi) || !(|s_hi));

`ifdef SUM_FXP_SAT_EN
  assign out_c = !ovf_c    ? s_fin[N-1:0] :
                 s_fin[W-1] ? {1'b1, {(N-1){1'b0}}} :
                              {1'b0, {(N-1){1'b1}}};
`else
  assign out_c = s_fin[N-1:0];
`endif

  logic [LAT-1:0] vld_pipe;
  assign out_valid = vld_pipe[LAT-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe   <= '0;
      out        <= '0;
      ovf        <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      if (en) begin
        // shift in_valid in at bit 0; the cast drops the bit shifted out
        vld_pipe <= LAT'({vld_pipe, in_valid});
        out      <= out_c;
        ovf      <= ovf_c;
      end
      // sticky samples the registered result; set beats clr
      if (en && out_valid && ovf) ovf_sticky <= 1'b1;
      else if (clr)               ovf_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sum_fxp_pipe.sv
module tb_sum_fxp_pipe;
  logic clk = 1'b0;
  logic rst, en, clr;

  logic            a_iv, a_ov, a_ovf, a_st;
  logic [4:0][7:0] a_in;
  logic [7:0]      a_out;
  logic            b_iv, b_ov, b_ovf, b_st;
  logic [0:0][7:0] b_in;
  logic [7:0]      b_out;
  logic            c_iv, c_ov, c_ovf, c_st;
  logic [7:0][7:0] c_in;
  logic [7:0]      c_out;

  int total = 0;
  int bad   = 0;

`ifdef SUM_FXP_SAT_EN
  localparam logic [7:0] A_POS = 8'h7F, A_NEG = 8'h80, C_NEG = 8'h80, C_POS = 8'h7F;
`else
  localparam logic [7:0] A_POS = 8'hC8, A_NEG = 8'h38, C_NEG = 8'h00, C_POS = 8'hF8;
`endif

  always #5 clk = ~clk;

  sum_fxp_pipe #(.size(5), .n_int(3), .n_mant(4), .adders_comb(2)) u_a (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .in_valid(a_iv), .in(a_in),
    .out_valid(a_ov), .out(a_out), .ovf(a_ovf), .ovf_sticky(a_st));

  sum_fxp_pipe #(.size(1), .n_int(3), .n_mant(4), .adders_comb(2)) u_b (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .in_valid(b_iv), .in(b_in),
    .out_valid(b_ov), .out(b_out), .ovf(b_ovf), .ovf_sticky(b_st));

  sum_fxp_pipe #(.size(8), .n_int(3), .n_mant(4), .adders_comb(1)) u_c (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .in_valid(c_iv), .in(c_in),
    .out_valid(c_ov), .out(c_out), .ovf(c_ovf), .ovf_sticky(c_st));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic [7:0] v0, v1, v2, v3, v4);
    a_in = {v4, v3, v2, v1, v0};
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; clr = 1'b0;
    a_iv = 1'b0; b_iv = 1'b0; c_iv = 1'b0;
    a_in = '0; b_in = '0; c_in = '0;
    #1;
    total++; if (a_out !== 8'h00) begin bad++; $display("FAIL rst_out got %h want 00", a_out); end
    total++; if (a_ov !== 1'b0) begin bad++; $display("FAIL rst_vld got %b want 0", a_ov); end
    total++; if (a_ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf got %b want 0", a_ovf); end
    total++; if (a_st !== 1'b0) begin bad++; $display("FAIL rst_sticky got %b want 0", a_st); end
    total++; if (c_ov !== 1'b0) begin bad++; $display("FAIL rst_c_vld got %b want 0", c_ov); end
    step(); step();
    #2 rst = 1'b1;
    step();
  endtask

  task automatic test_latency();
    set_a(8'd1, 8'd2, 8'd3, 8'd4, 8'd5); a_iv = 1'b1;
    step(); a_iv = 1'b0;
    total++; if (a_ov !== 1'b0) begin bad++; $display("FAIL lat_early got %b want 0", a_ov); end
    step();
    total++; if (a_ov !== 1'b1) begin bad++; $display("FAIL lat_vld got %b want 1", a_ov); end
    total++; if (a_out !== 8'd15) begin bad++; $display("FAIL lat_out got %h want 0f", a_out); end
    total++; if (a_ovf !== 1'b0) begin bad++; $display("FAIL lat_ovf got %b want 0", a_ovf); end
    step();
    total++; if (a_ov !== 1'b0) begin bad++; $display("FAIL lat_single got %b want 0", a_ov); end
  endtask

  task automatic test_sat();
    set_a(8'd100, 8'd100, 8'd0, 8'd0, 8'd0); a_iv = 1'b1;
    step(); a_iv = 1'b0;
    step();
    total++; if (a_ov !== 1'b1) begin bad++; $display("FAIL sat_pos_vld got %b want 1", a_ov); end
    total++; if (a_out !== A_POS) begin bad++; $display("FAIL sat_pos_out got %h want %h", a_out, A_POS); end
    total++; if (a_ovf !== 1'b1) begin bad++; $display("FAIL sat_pos_ovf got %b want 1", a_ovf); end
    step();
    total++; if (a_st !== 1'b1) begin bad++; $display("FAIL sat_sticky got %b want 1", a_st); end
    set_a(8'h9C, 8'h9C, 8'd0, 8'd0, 8'd0); a_iv = 1'b1;
    step(); a_iv = 1'b0;
    step();
    total++; if (a_out !== A_NEG) begin bad++; $display("FAIL sat_neg_out got %h want %h", a_out, A_NEG); end
    total++; if (a_ovf !== 1'b1) begin bad++; $display("FAIL sat_neg_ovf got %b want 1", a_ovf); end
    step();
  endtask

  task automatic test_sticky();
    clr = 1'b1; step(); clr = 1'b0;
    total++; if (a_st !== 1'b0) begin bad++; $display("FAIL stk_init_clr got %b want 0", a_st); end
    set_a(8'd100, 8'd100, 8'd0, 8'd0, 8'd0); a_iv = 1'b1;
    step(); step(); a_iv = 1'b0;
    total++; if (a_ovf !== 1'b1) begin bad++; $display("FAIL stk_ovf1 got %b want 1", a_ovf); end
    step();
    total++; if (a_st !== 1'b1) begin bad++; $display("FAIL stk_set got %b want 1", a_st); end
    clr = 1'b1; step();
    total++; if (a_st !== 1'b1) begin bad++; $display("FAIL stk_set_wins got %b want 1", a_st); end
    step(); clr = 1'b0;
    total++; if (a_st !== 1'b0) begin bad++; $display("FAIL stk_clr got %b want 0", a_st); end
  endtask

  task automatic test_stall();
    logic [4:0][7:0] vec [4];
    int         vi    [9] = '{0, 1, 2, 2, 2, 2, 3, 0, 0};
    logic       iv_s  [9] = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
    logic       en_s  [9] = '{1, 1, 0, 0, 0, 1, 1, 1, 1};
    logic       exp_v [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
    logic [7:0] exp_o [9] = '{8'h00, 8'h05, 8'h05, 8'h05, 8'h05, 8'h07, 8'hC5, 8'h77, 8'h00};
    vec[0] = {8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    vec[1] = {8'd0, 8'd0, 8'd0, 8'hFD, 8'd10};
    vec[2] = {8'd1, 8'd0, 8'hEC, 8'hEC, 8'hEC};
    vec[3] = {8'hFF, 8'd30, 8'd30, 8'd30, 8'd30};
    for (int k = 0; k < 9; k++) begin
      a_in = vec[vi[k]]; a_iv = iv_s[k]; en = en_s[k];
      step();
      total++; if (a_ov !== exp_v[k]) begin bad++; $display("FAIL stall_vld[%0d] got %b want %b", k, a_ov, exp_v[k]); end
      if (exp_v[k]) begin
        total++; if (a_out !== exp_o[k]) begin bad++; $display("FAIL stall_out[%0d] got %h want %h", k, a_out, exp_o[k]); end
        total++; if (a_ovf !== 1'b0) begin bad++; $display("FAIL stall_ovf[%0d] got %b want 0", k, a_ovf); end
      end
    end
    a_iv = 1'b0; en = 1'b1;
  endtask

  task automatic test_reset_midflight();
    set_a(8'd100, 8'd100, 8'd0, 8'd0, 8'd0); a_iv = 1'b1;
    step(); step(); step(); a_iv = 1'b0;
    total++; if (a_st !== 1'b1) begin bad++; $display("FAIL rmf_pre_sticky got %b want 1", a_st); end
    #2 rst = 1'b0;
    #1;
    total++; if (a_out !== 8'h00) begin bad++; $display("FAIL rmf_out got %h want 00", a_out); end
    total++; if (a_ov !== 1'b0) begin bad++; $display("FAIL rmf_vld got %b want 0", a_ov); end
    total++; if (a_ovf !== 1'b0) begin bad++; $display("FAIL rmf_ovf got %b want 0", a_ovf); end
    total++; if (a_st !== 1'b0) begin bad++; $display("FAIL rmf_sticky got %b want 0", a_st); end
    step();
    #2 rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (a_ov !== 1'b0) begin bad++; $display("FAIL rmf_spurious[%0d] got %b want 0", k, a_ov); end
    end
    set_a(8'd1, 8'd2, 8'd3, 8'd4, 8'd5); a_iv = 1'b1;
    step(); a_iv = 1'b0;
    total++; if (a_ov !== 1'b0) begin bad++; $display("FAIL rmf_early got %b want 0", a_ov); end
    step();
    total++; if (a_ov !== 1'b1) begin bad++; $display("FAIL rmf_new_vld got %b want 1", a_ov); end
    total++; if (a_out !== 8'd15) begin bad++; $display("FAIL rmf_new_out got %h want 0f", a_out); end
    step();
  endtask

  task automatic test_size1();
    b_in[0] = 8'hDB; b_iv = 1'b1;
    step();
    total++; if (b_ov !== 1'b1) begin bad++; $display("FAIL s1_vld got %b want 1", b_ov); end
    total++; if (b_out !== 8'hDB) begin bad++; $display("FAIL s1_out got %h want db", b_out); end
    total++; if (b_ovf !== 1'b0) begin bad++; $display("FAIL s1_ovf got %b want 0", b_ovf); end
    b_in[0] = 8'h80;
    step(); b_iv = 1'b0;
    total++; if (b_out !== 8'h80) begin bad++; $display("FAIL s1_min got %h want 80", b_out); end
    total++; if (b_ovf !== 1'b0) begin bad++; $display("FAIL s1_min_ovf got %b want 0", b_ovf); end
    step();
    total++; if (b_ov !== 1'b0) begin bad++; $display("FAIL s1_drop got %b want 0", b_ov); end
    total++; if (b_st !== 1'b0) begin bad++; $display("FAIL s1_sticky got %b want 0", b_st); end
  endtask

  task automatic test_back_to_back();
    logic [7:0][7:0] vec [4];
    logic [7:0] exp_o [4];
    logic       exp_f [4] = '{1, 1, 0, 0};
    vec[0] = {8{8'h80}};
    vec[1] = {8{8'h7F}};
    vec[2] = {8{8'hF0}};
    vec[3] = {8'd15, {7{8'd16}}};
    exp_o[0] = C_NEG; exp_o[1] = C_POS; exp_o[2] = 8'h80; exp_o[3] = 8'h7F;
    for (int k = 0; k < 8; k++) begin
      c_iv = (k < 4);
      c_in = (k < 4) ? vec[k] : '0;
      step();
      if (k >= 3 && k <= 6) begin
        total++; if (c_ov !== 1'b1) begin bad++; $display("FAIL b2b_vld[%0d] got %b want 1", k, c_ov); end
        total++; if (c_out !== exp_o[k-3]) begin bad++; $display("FAIL b2b_out[%0d] got %h want %h", k, c_out, exp_o[k-3]); end
        total++; if (c_ovf !== exp_f[k-3]) begin bad++; $display("FAIL b2b_ovf[%0d] got %b want %b", k, c_ovf, exp_f[k-3]); end
      end else begin
        total++; if (c_ov !== 1'b0) begin bad++; $display("FAIL b2b_idle[%0d] got %b want 0", k, c_ov); end
      end
      if (k == 4) begin
        total++; if (c_st !== 1'b1) begin bad++; $display("FAIL b2b_sticky got %b want 1", c_st); end
      end
    end
    c_iv = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_sat();
    test_sticky();
    test_stall();
    test_reset_midflight();
    test_size1();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sum_fxp_pipe.md
Name: sum_fxp_pipe

Overview:
Parametrised, pipelined signed fixed-point adder tree. Sums `size` inputs of format Q(n_int).(n_mant) plus sign. Successor to the combinational sum block, adding:
- valid tracking through the pipeline
- stall support
- internal guard bits
- overflow detection with sticky flag

Sits in the filter datapath after the coefficient multipliers.

Parameters:
- size, 2, number of operands summed (>=1)
- n_int, 8, integer bits excluding sign
- n_mant, 23, fractional bits
- adders_comb, 10, adder layers between pipeline registers (>=1)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  pipeline advance enable; low freezes all registers
- in_valid  in  1  operands valid this cycle
- in  in  size x (n_int+n_mant+1)  signed operands, two's complement
- out_valid  out  1  out holds a new sum
- out  out  n_int+n_mant+1  signed sum
- ovf  out  1  out was clamped (or wrapped) for this sample
- ovf_sticky  out  1  latched OR of ovf since reset or clr
- clr  in  1  synchronous clear of ovf_sticky

Behaviour:

Widths and arithmetic
- N = n_int+n_mant+1; L = $clog2(size) (L=0 when size=1); W = N+L.
- Operands are sign-extended to W before layer 0, so the tree never overflows internally.
- Layer i pairs adjacent entries. An odd leftover passes through unsummed, as in the existing tree: layer count per layer is ceil(prev/2).

Pipelining
- A register bank sits after layer i when (i+1) % adders_comb == 0.
- A final output register always follows the narrowing stage.
- Latency LAT = floor(L/adders_comb) + 1 cycles, counted in en-high cycles.
- size=1: LAT=1; out = in[0] registered, ovf never set.

Valid pipeline
- A shift register of LAT bits carries in_valid alongside the data.
- out_valid is the last bit of that register.
- Data registers load regardless of in_valid; only out_valid qualifies the result.

Stall
- en=0: every data, valid and ovf register holds its value. out, out_valid and ovf are frozen.
- ovf_sticky still responds to clr while stalled.

Narrowing (combinational from the final W-bit sum S, registered into out)
- S in [-2^(N-1), 2^(N-1)-1]: out = S[N-1:0], ovf=0.
- Otherwise: ovf=1 and out handling depends on SUM_FXP_SAT_EN (see below).

Overflow flags
- ovf is registered alongside out and is meaningful only while out_valid=1.
- ovf_sticky sets on any cycle with en & out_valid & ovf after the output register updates.
- clr=1 clears ovf_sticky. Set and clear in the same cycle: set wins.

Reset
- rst=0 asynchronously clears: all pipeline data registers, out=0, out_valid=0, ovf=0, ovf_sticky=0.
- Reset mid-operation discards all in-flight samples. No spurious out_valid after release.
- The first valid output comes LAT en-cycles after the first in_valid following release.

Back-to-back
- One sample accepted per en-high cycle; throughput is 1 sample per cycle.

Optional Feature:
Macro SUM_FXP_SAT_EN.
- Defined: on overflow, out clamps to 2^(N-1)-1 (positive S) or -2^(N-1) (negative S).
- Undefined: out = S[N-1:0], i.e. two's-complement wrap, matching legacy behaviour.
- ovf and ovf_sticky are produced identically in both builds.

Test Plan:
1. Latency/valid. size=5, n_int=3, n_mant=4 (N=8), adders_comb=2, so L=3 and LAT=2. Apply in={1,2,3,4,5} with a single in_valid pulse -> exactly 2 cycles later out=15, out_valid=1 for one cycle, ovf=0.
2. Saturation, same config with SUM_FXP_SAT_EN. in={100,100,0,0,0} -> out=127, ovf=1, ovf_sticky=1. in={-100,-100,0,0,0} -> out=-128. Without the macro, the first case gives out=-56 (200 wrapped to 8 bits), ovf=1.
3. Stall. Stream 4 consecutive valid samples and hold en=0 for 3 cycles mid-stream -> out/out_valid frozen during the stall; all 4 sums emerge in order, none lost or duplicated.
4. Reset mid-flight. Assert rst=0 asynchronously (between clock edges) while 2 samples are in flight -> out=0, out_valid=0, ovf_sticky=0 immediately; after release no out_valid until a new in_valid+LAT.
5. Sticky clear. Produce an overflow, then assert clr on a cycle that has another overflow -> ovf_sticky stays 1. Assert clr on a clean cycle -> ovf_sticky=0.
6. Degenerate/boundary configs.
   - size=1 -> LAT=1, out=in[0].
   - size=8, adders_comb=1 -> LAT=4. Max-negative operands {-128 x8} -> S=-1024, clamped to -128 with ovf=1.
